// File: rtl/adc_sample_source.sv
// rtl/adc_sample_source.sv - sample-rate pacer and serial ADC reader with strobe and overrun flag
// Optional ADC_OFFSET_BINARY_EN: treat the ADC word as offset binary instead of two's complement.
module adc_sample_source #(
    parameter int DIV       = 5000,
    parameter int SCLK_HALF = 4,
    parameter int PULSE     = 4
) (
    input  logic               qzt_clk,
    input  logic               reset,
    input  logic               adc_sdo,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    output logic signed [19:0] Vin,
    output logic               clk_in,
    output logic               overrun
);
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUB_MAX = (2 * SCLK_HALF > PULSE) ? 2 * SCLK_HALF : PULSE;
    localparam int SW      = $clog2(SUB_MAX + 1);

    localparam logic [CW-1:0] TICK_AT    = CW'(DIV - 1);
    localparam logic [SW-1:0] HALF       = SW'(SCLK_HALF);
    localparam logic [SW-1:0] HALF_END   = SW'(SCLK_HALF - 1);
    localparam logic [SW-1:0] PERIOD_END = SW'(2 * SCLK_HALF - 1);
    localparam logic [SW-1:0] PULSE_END  = SW'(PULSE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, STROBE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      tick_cnt;
    logic               tick;
    logic [SW-1:0]      sub_cnt, sub_cnt_nxt;
    logic [4:0]         bit_cnt, bit_cnt_nxt;
    logic [19:0]        shreg;
    logic               capture;
    logic signed [19:0] word_conv;

    assign tick = (tick_cnt == TICK_AT);

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        sub_cnt_nxt = sub_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                sub_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                if (tick) state_nxt = SETUP;
            end
            SETUP: begin
                if (sub_cnt == HALF_END) begin
                    sub_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                // sub_cnt 0..HALF-1 is the low phase; capture as sclk goes high
                capture = (sub_cnt == HALF);
                if (sub_cnt == PERIOD_END) begin
                    sub_cnt_nxt = '0;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 5'd19) state_nxt = DONE;
                end
            end
            DONE: begin
                sub_cnt_nxt = '0;
                state_nxt   = STROBE;
            end
            STROBE: begin
                if (sub_cnt == PULSE_END) begin
                    sub_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                sub_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

`ifdef ADC_OFFSET_BINARY_EN
    assign word_conv = {~shreg[19], shreg[18:0]};
`else
    assign word_conv = shreg;
`endif

    // Pin outputs are registered from the current state so they never glitch.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sub_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            Vin      <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            clk_in   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sub_cnt  <= sub_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            if (capture) shreg <= {shreg[18:0], adc_sdo};
            if (state == DONE) Vin <= word_conv;
            adc_cs_n <= !((state == SETUP) || (state == SHIFT));
            adc_sclk <= (state == SHIFT) && (sub_cnt >= HALF);
            clk_in   <= (state == STROBE);
            if (tick && (state != IDLE)) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_sample_source.sv
// tb/tb_adc_sample_source.sv - self-checking bench for adc_sample_source with a behavioural ADC
module tb_adc_sample_source;
    localparam int DIV          = 100;
    localparam int SH           = 2;
    localparam int PULSE        = 4;
    localparam int DIV_OV       = 60;
    localparam int TICK_TO_RISE = 41 * SH + 3;

    logic               clk     = 1'b0;
    logic               reset   = 1'b1;
    logic               reset60 = 1'b1;
    logic               sdo;
    logic               cs_n, sclk, clk_in, overrun;
    logic signed [19:0] vin;
    logic               sdo60   = 1'b0;
    logic               cs60, sclk60, clkin60, ovr60;
    logic signed [19:0] vin60;

    int passed = 0;
    int total  = 0;

    adc_sample_source #(.DIV(DIV), .SCLK_HALF(SH), .PULSE(PULSE)) dut (
        .qzt_clk(clk), .reset(reset), .adc_sdo(sdo), .adc_cs_n(cs_n),
        .adc_sclk(sclk), .Vin(vin), .clk_in(clk_in), .overrun(overrun)
    );

    adc_sample_source #(.DIV(DIV_OV), .SCLK_HALF(SH), .PULSE(PULSE)) dut60 (
        .qzt_clk(clk), .reset(reset60), .adc_sdo(sdo60), .adc_cs_n(cs60),
        .adc_sclk(sclk60), .Vin(vin60), .clk_in(clkin60), .overrun(ovr60)
    );

    always #5 clk = ~clk;

    // ADC: latches the word on CS fall, presents MSB, shifts on every sclk fall
    logic [19:0] adc_word   = 20'h0;
    logic [19:0] adc_shift  = 20'h0;
    logic        adc_active = 1'b0;
    always @(negedge cs_n or posedge cs_n or negedge sclk) begin
        if (cs_n) begin
            adc_active <= 1'b0;
        end else if (!adc_active) begin
            adc_active <= 1'b1;
            adc_shift  <= adc_word;
        end else begin
            adc_shift <= {adc_shift[18:0], 1'b0};
        end
    end
    assign sdo = adc_shift[19];

    int cyc   = 0;
    int cyc60 = 0;
    always @(posedge clk) begin
        cyc   <= reset ? 0 : cyc + 1;
        cyc60 <= reset60 ? 0 : cyc60 + 1;
    end

    int          csfall_q[$];
    int          rise_q[$];
    logic [19:0] vin_q[$];
    int          sclk_q[$];
    int          rise60_q[$];
    int          sclk_cnt   = 0;
    int          vin_bad    = 0;
    logic        prev_cs    = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        prev_clkin = 1'b0;
    logic        prev_clk60 = 1'b0;
    logic [19:0] prev_vin   = 20'h0;

    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            csfall_q.push_back(cyc);
            sclk_cnt <= 0;
        end else if (!prev_sclk && sclk && !cs_n) begin
            sclk_cnt <= sclk_cnt + 1;
        end
        if (!prev_clkin && clk_in) begin
            rise_q.push_back(cyc);
            vin_q.push_back(vin);
            sclk_q.push_back(sclk_cnt);
            if (vin !== prev_vin) vin_bad <= vin_bad + 1;
        end else if (prev_clkin && clk_in && vin !== prev_vin) begin
            vin_bad <= vin_bad + 1;
        end
        if (!prev_clk60 && clkin60) rise60_q.push_back(cyc60);
        prev_cs    <= cs_n;
        prev_sclk  <= sclk;
        prev_clkin <= clk_in;
        prev_clk60 <= clkin60;
        prev_vin   <= vin;
    end

    function automatic int exp_vin(input logic [19:0] w);
        int u;
        u = int'(w);
`ifdef ADC_OFFSET_BINARY_EN
        return u - 524288;
`else
        return (u >= 524288) ? u - 1048576 : u;
`endif
    endfunction

    task automatic wait_until_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < target + 10) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_until_cyc60(input int target);
        int guard;
        guard = 0;
        while (cyc60 < target && guard < target + 10) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_sample(input logic [19:0] word, input string name);
        int n, waited, got;
        adc_word = word;
        n = rise_q.size();
        waited = 0;
        while (rise_q.size() == n && waited < 3 * DIV) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (rise_q.size() == n) begin
            $display("FAIL %s_strobe: no clk_in rise in %0d cycles, required one", name, waited);
            total++;
        end else begin
            got = $signed(vin_q[n]);
            if ($isunknown(vin_q[n]) || got != exp_vin(word))
                $display("FAIL %s_vin: got %0d (%h), required %0d", name, got, vin_q[n], exp_vin(word));
            else passed++;
            total++;
            if (sclk_q[n] != 20)
                $display("FAIL %s_sclk_count: got %0d rising edges, required 20", name, sclk_q[n]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        int n_cs, n_rise;
        reset = 1'b1;
        adc_word = 20'h12345;
        repeat (3) @(negedge clk);
        total++;
        if ({cs_n, sclk, clk_in, overrun} !== 4'b1000 || vin !== 20'sd0)
            $display("FAIL reset_outputs: cs_n=%b sclk=%b clk_in=%b overrun=%b Vin=%h, required 1 0 0 0 00000",
                     cs_n, sclk, clk_in, overrun, vin);
        else passed++;
        n_cs = csfall_q.size();
        n_rise = rise_q.size();
        reset = 1'b0;
        wait_until_cyc(50);
        total++;
        if ({cs_n, sclk, clk_in, overrun} !== 4'b1000 || vin !== 20'sd0)
            $display("FAIL reset_hold: cs_n=%b sclk=%b clk_in=%b overrun=%b Vin=%h, required 1 0 0 0 00000",
                     cs_n, sclk, clk_in, overrun, vin);
        else passed++;
        wait_until_cyc(190);
        total++;
        if (csfall_q.size() <= n_cs)
            $display("FAIL first_cs_fall: missing, required at cycle %0d", DIV + 1);
        else if (csfall_q[n_cs] != DIV + 1)
            $display("FAIL first_cs_fall: cycle %0d, required %0d", csfall_q[n_cs], DIV + 1);
        else passed++;
        total++;
        if (rise_q.size() <= n_rise)
            $display("FAIL first_clk_in_rise: missing, required at cycle %0d", DIV - 1 + TICK_TO_RISE);
        else if (rise_q[n_rise] != DIV - 1 + TICK_TO_RISE)
            $display("FAIL first_clk_in_rise: cycle %0d, required %0d", rise_q[n_rise], DIV - 1 + TICK_TO_RISE);
        else passed++;
    endtask

    task automatic test_basic();
        run_sample(20'h12345, "word_12345");
    endtask

    task automatic test_full_scale();
        run_sample(20'hFFFFF, "word_fffff");
        run_sample(20'h80000, "word_80000");
        run_sample(20'h00000, "word_00000");
        run_sample(20'h7FFFF, "word_7ffff");
    endtask

    task automatic test_alternating();
        int base, bad0;
        base = rise_q.size();
        bad0 = vin_bad;
        for (int i = 0; i < 4; i++)
            run_sample((i % 2 == 0) ? 20'h7FFFF : 20'h80000, "alternating");
        for (int i = 1; i < 4; i++) begin
            total++;
            if (rise_q.size() < base + 4)
                $display("FAIL alt_period: only %0d strobes, required 4", rise_q.size() - base);
            else if (rise_q[base + i] - rise_q[base + i - 1] != DIV)
                $display("FAIL alt_period: interval %0d, required %0d", rise_q[base + i] - rise_q[base + i - 1], DIV);
            else passed++;
        end
        total++;
        if (vin_bad != bad0)
            $display("FAIL vin_stability: %0d changes near/under clk_in high, required 0", vin_bad - bad0);
        else passed++;
    endtask

    task automatic test_random();
        logic [19:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 20'($urandom);
            run_sample(w, "random_word");
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] w;
        int n, guard;
        w = 20'($urandom);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        adc_word = w;
        reset = 1'b0;
        guard = 0;
        while (!(cs_n === 1'b0 && sclk_cnt == 9) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 300) $display("FAIL mid_reach_10th: sclk count %0d, required 9 within 300 cycles", sclk_cnt);
        else passed++;
        repeat (2) @(negedge clk);
        n = rise_q.size();
        reset = 1'b1;
        #1;
        total++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || vin !== 20'sd0)
            $display("FAIL mid_reset_outputs: cs_n=%b sclk=%b Vin=%h, required 1 0 00000", cs_n, sclk, vin);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_until_cyc(95);
        total++;
        if (rise_q.size() != n || vin !== 20'sd0)
            $display("FAIL mid_no_strobe: %0d strobes Vin=%h, required 0 strobes Vin=00000", rise_q.size() - n, vin);
        else passed++;
        run_sample(w, "post_reset_word");
        total++;
        if (csfall_q.size() == 0 || csfall_q[$] != DIV + 1)
            $display("FAIL post_reset_cs_fall: cycle %0d, required %0d",
                     (csfall_q.size() == 0) ? -1 : csfall_q[$], DIV + 1);
        else passed++;
    endtask

    task automatic test_overrun();
        int base;
        reset60 = 1'b1;
        repeat (2) @(negedge clk);
        reset60 = 1'b0;
        base = rise60_q.size();
        wait_until_cyc60(110);
        total++;
        if (ovr60 !== 1'b0) $display("FAIL overrun_before_2nd_tick: got %b, required 0", ovr60);
        else passed++;
        wait_until_cyc60(125);
        total++;
        if (ovr60 !== 1'b1) $display("FAIL overrun_after_2nd_tick: got %b, required 1", ovr60);
        else passed++;
        wait_until_cyc60(400);
        total++;
        if (rise60_q.size() < base + 3)
            $display("FAIL overrun_strobes: %0d strobes, required 3", rise60_q.size() - base);
        else if (rise60_q[base] != DIV_OV - 1 + TICK_TO_RISE)
            $display("FAIL overrun_first_strobe: cycle %0d, required %0d", rise60_q[base], DIV_OV - 1 + TICK_TO_RISE);
        else passed++;
        for (int i = 1; i < 3; i++) begin
            total++;
            if (rise60_q.size() < base + 3)
                $display("FAIL overrun_period: missing strobe %0d", i);
            else if (rise60_q[base + i] - rise60_q[base + i - 1] != 2 * DIV_OV)
                $display("FAIL overrun_period: interval %0d, required %0d",
                         rise60_q[base + i] - rise60_q[base + i - 1], 2 * DIV_OV);
            else passed++;
        end
        total++;
        if (ovr60 !== 1'b1) $display("FAIL overrun_sticky: got %b, required 1", ovr60);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_alternating();
        test_random();
        test_reset_mid();
        test_overrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
